// File: rtl/sdmac_fifo_pkg.sv
// rtl/sdmac_fifo_pkg.sv - shared constants and byte-lane helpers for the SDMAC data FIFO
package sdmac_fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    // Lane 0 is the most significant byte (68k big-endian order)
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] w;
        w = word;
        case (lane)
            LANE0:   w[31:24] = data;
            LANE1:   w[23:16] = data;
            LANE2:   w[15:8]  = data;
            default: w[7:0]   = data;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            LANE0:   b = word[31:24];
            LANE1:   b = word[23:16];
            LANE2:   b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sdmac_fifo_ptr.sv
// rtl/sdmac_fifo_ptr.sv - wrapping FIFO pointer with qualified increment and synchronous clear
module sdmac_fifo_ptr #(
    parameter int W = 3
) (
    input  logic         CPUCLK,
    input  logic         RESET_,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Power-of-two depth lets the natural binary rollover provide the wrap
    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sdmac_fifo.sv
// rtl/sdmac_fifo.sv - longword FIFO between the SCSI state machine and the SDMAC bus side
module sdmac_fifo
    import sdmac_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic        CPUCLK,
    input  logic        RESET_,
    input  logic        FIFOFLUSH,
    input  logic        LLWORD,
    input  logic [31:0] ID_in,
    input  logic        S2F,
    input  logic [7:0]  SD_in,
    input  logic        INCNI,
    input  logic        INCNO,
    input  logic        INCBO,
    output logic [31:0] FIFO_ID,
    output logic [7:0]  FIFO_SD,
    output logic        FIFOFULL,
    output logic        FIFOEMPTY,
    output logic        BOEQ3
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] ni;
    logic [PW-1:0] no;
    logic [1:0]    bo;
    logic [CW-1:0] count;

    logic          no_ok;
    logic          ni_ok;
    logic          wr_en;
    logic [31:0]   wr_word;

    assign FIFOEMPTY = (count == '0);
    assign FIFOFULL  = (count == DEPTH_CNT);
    assign BOEQ3     = (bo == LANE3);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign no_ok = INCNO && !FIFOEMPTY && !FIFOFLUSH;
    assign ni_ok = INCNI && (!FIFOFULL || no_ok) && !FIFOFLUSH;
    assign wr_en = (LLWORD || S2F) && (!FIFOFULL || no_ok) && !FIFOFLUSH;

    always_comb begin
        wr_word = LLWORD ? ID_in : mem[ni];
        if (S2F) begin
            wr_word = lane_insert(wr_word, bo, SD_in);
        end
    end

    sdmac_fifo_ptr #(.W(PW)) u_ni (
        .CPUCLK (CPUCLK),
        .RESET_ (RESET_),
        .clr    (FIFOFLUSH),
        .inc    (ni_ok),
        .ptr    (ni)
    );

    sdmac_fifo_ptr #(.W(PW)) u_no (
        .CPUCLK (CPUCLK),
        .RESET_ (RESET_),
        .clr    (FIFOFLUSH),
        .inc    (no_ok),
        .ptr    (no)
    );

    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            count <= '0;
            bo    <= LANE0;
        end else if (FIFOFLUSH) begin
            count <= '0;
            bo    <= LANE0;
        end else begin
            count <= count + CW'(ni_ok) - CW'(no_ok);
            if (INCBO) begin
                bo <= bo + 2'd1;
            end
        end
    end

    // Flush keeps storage; only reset scrubs it
    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[ni] <= wr_word;
        end
    end

    assign FIFO_ID = mem[no];
    assign FIFO_SD = lane_extract(mem[no], bo);

endmodule
